// File: rtl/boot_release_ctrl_if.sv
// Boot/reset handshake bundle between the reset sequencer and the release controller.
interface boot_release_ctrl_if;
   logic       srstn_i;
   logic       mem_repair_done_i;
   logic       run_stall_i;
   logic       a0_bypass_i;
   logic       core_rst_o;
   logic       fetch_en_o;
   logic       boot_addr_sel_o;
   logic       boot_err_o;
   logic [2:0] boot_state_o;
   logic [7:0] release_cnt_o;

   // Sequencer side: drives the boot levels, observes the core-side controls.
   modport master (
      output srstn_i, mem_repair_done_i, run_stall_i, a0_bypass_i,
      input  core_rst_o, fetch_en_o, boot_addr_sel_o, boot_err_o,
      input  boot_state_o, release_cnt_o
   );

   // Controller side.
   modport slave (
      input  srstn_i, mem_repair_done_i, run_stall_i, a0_bypass_i,
      output core_rst_o, fetch_en_o, boot_addr_sel_o, boot_err_o,
      output boot_state_o, release_cnt_o
   );
endinterface

// File: rtl/boot_release_ctrl.sv
// Core reset release / fetch enable controller. Synchronises the boot levels,
// orders reset release behind memory repair, holds core reset for a fixed
// window, gates fetch on run_stall and flags a repair timeout.
module boot_release_ctrl #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned HOLD_CYCLES    = 16,
   parameter int unsigned REPAIR_TIMEOUT = 1024
) (
   input logic               clk_i,
   input logic               rst_i,
   boot_release_ctrl_if.slave bus
);

   localparam int unsigned CNT_SPAN = (HOLD_CYCLES > REPAIR_TIMEOUT) ? HOLD_CYCLES : REPAIR_TIMEOUT;
   localparam int unsigned CNT_W    = $clog2(CNT_SPAN) + 1;
   localparam int unsigned REL_W    = 8;
   localparam int unsigned ST_W     = 3;

   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(REPAIR_TIMEOUT - 1);
   localparam logic [REL_W-1:0] REL_MAX      = '1;

   localparam logic [ST_W-1:0] ST_WAIT_SYS    = 3'd0;
   localparam logic [ST_W-1:0] ST_WAIT_REPAIR = 3'd1;
   localparam logic [ST_W-1:0] ST_HOLD        = 3'd2;
   localparam logic [ST_W-1:0] ST_WAIT_RUN    = 3'd3;
   localparam logic [ST_W-1:0] ST_RUN         = 3'd4;
   localparam logic [ST_W-1:0] ST_STALL       = 3'd5;
   localparam logic [ST_W-1:0] ST_ERROR       = 3'd6;

   logic [SYNC_STAGES-1:0] sync_srstn, sync_repair, sync_stall;
   logic                   s_srstn, s_repair, s_stall;

   logic [ST_W-1:0]  state_q, state_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic [REL_W-1:0] rel_q, rel_nxt;
   logic             err_q, err_nxt;
   logic             sel_q, sel_nxt;
   logic             core_rst_q, core_rst_nxt;
   logic             fetch_en_q, fetch_en_nxt;

   // Multi-flop synchronisers for the asynchronous boot levels.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_srstn  <= '0;
         sync_repair <= '0;
         sync_stall  <= '0;
      end else begin
         sync_srstn  <= {sync_srstn[SYNC_STAGES-2:0],  bus.srstn_i};
         sync_repair <= {sync_repair[SYNC_STAGES-2:0], bus.mem_repair_done_i};
         sync_stall  <= {sync_stall[SYNC_STAGES-2:0],  bus.run_stall_i};
      end
   end

   assign s_srstn  = sync_srstn[SYNC_STAGES-1];
   assign s_repair = sync_repair[SYNC_STAGES-1];
   assign s_stall  = sync_stall[SYNC_STAGES-1];

   // State, counters and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_WAIT_SYS;
         cnt_q      <= '0;
         rel_q      <= '0;
         err_q      <= 1'b0;
         sel_q      <= 1'b0;
         core_rst_q <= 1'b1;
         fetch_en_q <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         cnt_q      <= cnt_nxt;
         rel_q      <= rel_nxt;
         err_q      <= err_nxt;
         sel_q      <= sel_nxt;
         core_rst_q <= core_rst_nxt;
         fetch_en_q <= fetch_en_nxt;
      end
   end

   // Next-state logic; outputs are decoded from the next state so they
   // register in the same cycle as the state they belong to.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = '0;
      rel_nxt   = rel_q;
      err_nxt   = err_q;
      sel_nxt   = sel_q;

      if (!s_srstn) begin
         state_nxt = ST_WAIT_SYS;
      end else begin
         case (state_q)
            ST_WAIT_SYS:    state_nxt = ST_WAIT_REPAIR;
            ST_WAIT_REPAIR: begin
               if (s_repair) begin
                  state_nxt = ST_HOLD;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  state_nxt = ST_ERROR;
                  err_nxt   = 1'b1;
               end else begin
                  cnt_nxt = cnt_q + CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (!s_repair) begin
                  state_nxt = ST_WAIT_REPAIR;
               end else if (cnt_q == HOLD_LAST) begin
                  state_nxt = ST_WAIT_RUN;
                  sel_nxt   = bus.a0_bypass_i;
                  if (rel_q != REL_MAX) rel_nxt = rel_q + REL_W'(1);
               end else begin
                  cnt_nxt = cnt_q + CNT_W'(1);
               end
            end
            ST_WAIT_RUN:    if (!s_stall) state_nxt = ST_RUN;
            ST_RUN:         if (s_stall)  state_nxt = ST_STALL;
            ST_STALL:       if (!s_stall) state_nxt = ST_RUN;
            ST_ERROR:       state_nxt = ST_ERROR;
            default:        state_nxt = ST_WAIT_SYS;
         endcase
      end

      core_rst_nxt = (state_nxt == ST_WAIT_SYS) || (state_nxt == ST_WAIT_REPAIR) ||
                     (state_nxt == ST_HOLD)     || (state_nxt == ST_ERROR);
      fetch_en_nxt = (state_nxt == ST_RUN);
   end

   assign bus.core_rst_o      = core_rst_q;
   assign bus.fetch_en_o      = fetch_en_q;
   assign bus.boot_addr_sel_o = sel_q;
   assign bus.boot_err_o      = err_q;
   assign bus.boot_state_o    = state_q;
   assign bus.release_cnt_o   = rel_q;

endmodule

// File: tb/tb_boot_release_ctrl.sv
// Self-checking bench for boot_release_ctrl: directed boot scenarios followed by
// randomized input traffic, compared every cycle against a phase/timestamp model.
module tb_boot_release_ctrl;
   localparam int unsigned SYNC = 2;
   localparam int unsigned HOLD = 4;
   localparam int unsigned TMO  = 8;

   localparam int P_WAIT_SYS = 0, P_WAIT_REPAIR = 1, P_HOLD = 2, P_WAIT_RUN = 3;
   localparam int P_RUN = 4, P_STALL = 5, P_ERROR = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   boot_release_ctrl_if bus ();

   boot_release_ctrl #(
      .SYNC_STAGES   (SYNC),
      .HOLD_CYCLES   (HOLD),
      .REPAIR_TIMEOUT(TMO)
   ) u_dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: current phase, the cycle the phase was entered, and the
   // history of sampled inputs that the synchronised view lags behind.
   int cyc = 0;
   int m_phase, m_enter, m_rel;
   bit m_err, m_sel;
   bit q_srstn[$], q_rep[$], q_stall[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic void enter(input int ph);
      m_phase = ph;
      m_enter = cyc + 1;
   endfunction

   function automatic void model_reset();
      enter(P_WAIT_SYS);
      m_rel = 0;
      m_err = 1'b0;
      m_sel = 1'b0;
      q_srstn.delete(); q_rep.delete(); q_stall.delete();
      for (int i = 0; i < int'(SYNC); i++) begin
         q_srstn.push_back(1'b0); q_rep.push_back(1'b0); q_stall.push_back(1'b0);
      end
   endfunction

   function automatic void model_edge();
      bit sv, rp, st;
      int age;
      if (rst) begin
         model_reset();
      end else begin
         sv = q_srstn.pop_front(); q_srstn.push_back(bus.srstn_i);
         rp = q_rep.pop_front();   q_rep.push_back(bus.mem_repair_done_i);
         st = q_stall.pop_front(); q_stall.push_back(bus.run_stall_i);
         age = cyc - m_enter;
         if (!sv) enter(P_WAIT_SYS);
         else if (m_phase == P_WAIT_SYS) enter(P_WAIT_REPAIR);
         else if (m_phase == P_WAIT_REPAIR) begin
            if (rp) enter(P_HOLD);
            else if (age >= int'(TMO) - 1) begin enter(P_ERROR); m_err = 1'b1; end
         end else if (m_phase == P_HOLD) begin
            if (!rp) enter(P_WAIT_REPAIR);
            else if (age >= int'(HOLD) - 1) begin
               enter(P_WAIT_RUN);
               m_sel = bus.a0_bypass_i;
               m_rel = (m_rel < 255) ? m_rel + 1 : 255;
            end
         end else if (m_phase == P_WAIT_RUN || m_phase == P_STALL) begin
            if (!st) enter(P_RUN);
         end else if (m_phase == P_RUN) begin
            if (st) enter(P_STALL);
         end
      end
      cyc++;
   endfunction

   task automatic check_outputs();
      bit exp_rst;
      exp_rst = (m_phase == P_WAIT_SYS) || (m_phase == P_WAIT_REPAIR) ||
                (m_phase == P_HOLD) || (m_phase == P_ERROR);
      chk("state",     32'(bus.boot_state_o),    32'(m_phase));
      chk("core_rst",  32'(bus.core_rst_o),      32'(exp_rst));
      chk("fetch_en",  32'(bus.fetch_en_o),      32'(m_phase == P_RUN));
      chk("addr_sel",  32'(bus.boot_addr_sel_o), 32'(m_sel));
      chk("boot_err",  32'(bus.boot_err_o),      32'(m_err));
      chk("rel_cnt",   32'(bus.release_cnt_o),   32'(m_rel));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   initial begin
      int low_cnt;
      bit rst_dropped;

      bus.srstn_i = 1'b0; bus.mem_repair_done_i = 1'b0;
      bus.run_stall_i = 1'b1; bus.a0_bypass_i = 1'b0;
      model_reset();
      repeat (3) step();
      chk("reset_state",    32'(bus.boot_state_o),  32'd0);
      chk("reset_core_rst", 32'(bus.core_rst_o),    32'd1);
      chk("reset_fetch",    32'(bus.fetch_en_o),    32'd0);
      chk("reset_err",      32'(bus.boot_err_o),    32'd0);
      chk("reset_rel",      32'(bus.release_cnt_o), 32'd0);

      // Nominal boot: srstn at cycle 0, repair at 5, stall released at 20.
      rst = 1'b0; bus.srstn_i = 1'b1; bus.a0_bypass_i = 1'b1;
      for (int t = 1; t <= 26; t++) begin
         step();
         if (t == 5)  bus.mem_repair_done_i = 1'b1;
         if (t == 20) bus.run_stall_i = 1'b0;
         if (t == 2)  chk("nom_state_c2",  32'(bus.boot_state_o), 32'd0);
         if (t == 3)  chk("nom_state_c3",  32'(bus.boot_state_o), 32'd1);
         if (t == 8)  chk("nom_state_c8",  32'(bus.boot_state_o), 32'd2);
         if (t == 11) chk("nom_rst_c11",   32'(bus.core_rst_o),   32'd1);
         if (t == 12) chk("nom_rst_c12",   32'(bus.core_rst_o),   32'd0);
         if (t == 22) chk("nom_fetch_c22", 32'(bus.fetch_en_o),   32'd0);
         if (t == 23) chk("nom_fetch_c23", 32'(bus.fetch_en_o),   32'd1);
      end
      chk("nom_rel", 32'(bus.release_cnt_o),   32'd1);
      chk("nom_sel", 32'(bus.boot_addr_sel_o), 32'd1);

      // Stall pulse of 5 cycles while running.
      bus.run_stall_i = 1'b1;
      low_cnt = 0; rst_dropped = 1'b0;
      for (int t = 1; t <= 14; t++) begin
         step();
         if (t == 5) bus.run_stall_i = 1'b0;
         if (!bus.fetch_en_o) low_cnt++;
         if (bus.core_rst_o) rst_dropped = 1'b1;
         if (t == 2) chk("stall_fetch_c2", 32'(bus.fetch_en_o), 32'd1);
         if (t == 3) chk("stall_fetch_c3", 32'(bus.fetch_en_o), 32'd0);
      end
      chk("stall_low_cycles", 32'(low_cnt),     32'd5);
      chk("stall_core_rst",   32'(rst_dropped), 32'd0);

      // System reset while running, then reboot with a new strap.
      bus.srstn_i = 1'b0; bus.a0_bypass_i = 1'b0;
      for (int t = 1; t <= 3; t++) begin
         step();
         if (t == 2) chk("midrun_state_c2", 32'(bus.boot_state_o), 32'd4);
      end
      chk("midrun_state", 32'(bus.boot_state_o), 32'd0);
      chk("midrun_rst",   32'(bus.core_rst_o),   32'd1);
      chk("midrun_fetch", 32'(bus.fetch_en_o),   32'd0);
      bus.srstn_i = 1'b1;
      repeat (12) step();
      chk("reboot_rel", 32'(bus.release_cnt_o),   32'd2);
      chk("reboot_sel", 32'(bus.boot_addr_sel_o), 32'd0);
      chk("reboot_run", 32'(bus.boot_state_o),    32'd4);

      // Repair drops at HOLD counter 2, then times out into ERROR.
      bus.srstn_i = 1'b0;
      repeat (3) step();
      bus.srstn_i = 1'b1;
      rst_dropped = 1'b0;
      for (int t = 1; t <= 16; t++) begin
         step();
         if (t == 4) bus.mem_repair_done_i = 1'b0;
         if (!bus.core_rst_o) rst_dropped = 1'b1;
         if (t == 6)  chk("drop_hold_c6",  32'(bus.boot_state_o), 32'd2);
         if (t == 7)  chk("drop_wr_c7",    32'(bus.boot_state_o), 32'd1);
         if (t == 14) chk("tmo_wr_c14",    32'(bus.boot_state_o), 32'd1);
         if (t == 15) chk("tmo_err_c15",   32'(bus.boot_state_o), 32'd6);
      end
      chk("drop_core_rst_held", 32'(rst_dropped),       32'd0);
      chk("drop_rel",           32'(bus.release_cnt_o), 32'd2);
      chk("tmo_err_flag",       32'(bus.boot_err_o),    32'd1);
      chk("tmo_core_rst",       32'(bus.core_rst_o),    32'd1);

      // One-cycle srstn pulse leaves ERROR but keeps the sticky flag.
      bus.srstn_i = 1'b0;
      step();
      bus.srstn_i = 1'b1;
      repeat (2) step();
      chk("pulse_state", 32'(bus.boot_state_o), 32'd0);
      chk("pulse_err",   32'(bus.boot_err_o),   32'd1);

      // Repeated reboots drive the release counter into saturation.
      bus.mem_repair_done_i = 1'b1;
      for (int r = 0; r < 260; r++) begin
         bus.srstn_i = 1'b0;
         repeat (3) step();
         bus.srstn_i = 1'b1;
         bus.a0_bypass_i = 1'($urandom_range(1));
         repeat (10) step();
      end
      chk("sat_rel", 32'(bus.release_cnt_o), 32'd255);

      // Only rst clears the error flag.
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_clears_err", 32'(bus.boot_err_o), 32'd0);

      // Randomized traffic on all inputs, including occasional rst.
      for (int t = 0; t < 3000; t++) begin
         if ($urandom_range(39) == 0) bus.srstn_i = ~bus.srstn_i;
         if ($urandom_range(11) == 0) bus.mem_repair_done_i = ~bus.mem_repair_done_i;
         if ($urandom_range(7) == 0)  bus.run_stall_i = ~bus.run_stall_i;
         if ($urandom_range(3) == 0)  bus.a0_bypass_i = ~bus.a0_bypass_i;
         rst = ($urandom_range(399) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
